// File: rtl/mouse_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mouse_pkg
// Description : Shared types and constants for the PS/2 mouse position
//               tracker. Holds the packet-assembly state encoding and the
//               bit positions of the fields in PS/2 packet byte 0.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_pkg;

  // Packet-assembly states. BYTE3 is only reachable in 4-byte
  // (IntelliMouse) builds.
  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } state_t;

  // Byte 0 field positions
  localparam int BTN_L_BIT    = 0;
  localparam int BTN_R_BIT    = 1;
  localparam int PKT_SYNC_BIT = 3;  // always 1 in a genuine byte 0
  localparam int X_SIGN_BIT   = 4;
  localparam int Y_SIGN_BIT   = 5;
  localparam int X_OVF_BIT    = 6;
  localparam int Y_OVF_BIT    = 7;

endpackage : mouse_pkg
`default_nettype wire

// File: rtl/mouse_axis_update.sv
`default_nettype none
// ============================================================================
// Module      : mouse_axis_update
// Description : Combinational single-axis cursor update. Adds (or, with
//               NEGATE=1, subtracts) a 9-bit signed PS/2 delta to the current
//               position and clamps the result to 0..max_pos (no wrap).
// Parameters  : NEGATE  - 1: result = pos - delta, 0: result = pos + delta
// Ports       : pos      in  12  current position (unsigned)
//               delta    in  9   signed movement delta
//               max_pos  in  12  largest legal position
//               clamped  out 12  updated, clamped position
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_axis_update #(
  parameter bit NEGATE = 1'b0
) (
  input  logic        [11:0] pos,
  input  logic signed [8:0]  delta,
  input  logic        [11:0] max_pos,
  output logic        [11:0] clamped
);

  // 14-bit signed arithmetic: wide enough for any 12-bit position plus or
  // minus the full 9-bit delta range, including negating -256.
  logic signed [13:0] w_pos;
  logic signed [13:0] w_max;
  logic signed [13:0] w_delta;
  logic signed [13:0] w_sum;

  assign w_pos   = signed'({2'b00, pos});
  assign w_max   = signed'({2'b00, max_pos});
  assign w_delta = {{5{delta[8]}}, delta};
  assign w_sum   = NEGATE ? (w_pos - w_delta) : (w_pos + w_delta);

  always_comb begin
    clamped = w_sum[11:0];
    if (w_sum < 14'sd0) begin
      clamped = '0;
    end else if (w_sum > w_max) begin
      clamped = max_pos;
    end
  end

endmodule : mouse_axis_update
`default_nettype wire

// File: rtl/mouse_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mouse_position_tracker
// Description : Assembles PS/2 mouse packets from the byte receiver and
//               integrates their deltas into an absolute cursor position
//               clamped to 0..MAX_X / 0..MAX_Y, for the cursor overlay.
//               A partial packet idle for TIMEOUT_CYCLES is discarded so the
//               framer resynchronises on the next byte with the sync bit set.
// Config      : `define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets and
//               the wheel output; undefined gives 3-byte packets, no wheel.
// Parameters  : MAX_X, MAX_Y     - largest legal xpos / ypos
//               TIMEOUT_CYCLES   - idle cycles allowed inside one packet
// Ports       : clk           in  1   system / pixel clock
//               rst           in  1   synchronous active-high reset
//               rx_data       in  8   PS/2 byte from receiver
//               rx_valid      in  1   strobe, rx_data valid this cycle
//               xpos, ypos    out 12  cursor position (ypos 0 = top row)
//               left, right   out 1   button states from byte 0
//               packet_valid  out 1   strobe, packet applied this cycle
//               wheel         out 4   signed Z of last packet (wheel build)
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int MAX_X          = 799,
  parameter int MAX_Y          = 599,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic        [7:0] rx_data,
  input  logic              rx_valid,
  output logic       [11:0] xpos,
  output logic       [11:0] ypos,
  output logic              left,
  output logic              right,
  output logic              packet_valid
`ifdef MOUSE_WHEEL_EN
  ,
  output logic signed [3:0] wheel
`endif
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;

  // Byte 0 fields held for the rest of the packet
  logic       r_btn_l;
  logic       r_btn_r;
  logic       r_x_sign;
  logic       r_y_sign;
  logic       r_x_ovf;
  logic       r_y_ovf;
  logic [7:0] r_byte1;
`ifdef MOUSE_WHEEL_EN
  logic [7:0] r_byte2;
`endif

  logic               w_timeout;
  state_t             w_state_eff;
  logic               w_accept;
  logic        [7:0]  w_byte2;
  logic signed [8:0]  w_dx;
  logic signed [8:0]  w_dy;
  logic        [11:0] w_x_next;
  logic        [11:0] w_y_next;

  // A timeout takes effect in the same cycle, so a byte arriving then is
  // judged as a fresh byte 0.
  assign w_timeout   = (r_state != BYTE0) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES));
  assign w_state_eff = w_timeout ? BYTE0 : r_state;
  assign w_accept    = rx_valid && ((w_state_eff != BYTE0) || rx_data[PKT_SYNC_BIT]);

  // In 3-byte mode the Y byte is the final byte and is used straight off
  // the receiver; in 4-byte mode it was captured the cycle before.
`ifdef MOUSE_WHEEL_EN
  assign w_byte2 = r_byte2;
`else
  assign w_byte2 = rx_data;
`endif

  // An overflow flag means the delta is meaningless, so treat it as no motion
  assign w_dx = r_x_ovf ? 9'sd0 : signed'({r_x_sign, r_byte1});
  assign w_dy = r_y_ovf ? 9'sd0 : signed'({r_y_sign, w_byte2});

  mouse_axis_update #(.NEGATE(1'b0)) u_axis_x (
    .pos     (xpos),
    .delta   (w_dx),
    .max_pos (12'(MAX_X)),
    .clamped (w_x_next)
  );

  // PS/2 +Y is up while screen rows grow downward
  mouse_axis_update #(.NEGATE(1'b1)) u_axis_y (
    .pos     (ypos),
    .delta   (w_dy),
    .max_pos (12'(MAX_Y)),
    .clamped (w_y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BYTE0;
      r_cnt        <= '0;
      r_btn_l      <= 1'b0;
      r_btn_r      <= 1'b0;
      r_x_sign     <= 1'b0;
      r_y_sign     <= 1'b0;
      r_x_ovf      <= 1'b0;
      r_y_ovf      <= 1'b0;
      r_byte1      <= '0;
`ifdef MOUSE_WHEEL_EN
      r_byte2      <= '0;
      wheel        <= '0;
`endif
      xpos         <= '0;
      ypos         <= '0;
      left         <= 1'b0;
      right        <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      r_state      <= w_state_eff;

      // Idle counter only runs while a packet is partially assembled
      if (w_accept || (w_state_eff == BYTE0)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (rx_valid) begin
        case (w_state_eff)
          BYTE0: begin
            if (rx_data[PKT_SYNC_BIT]) begin
              r_btn_l  <= rx_data[BTN_L_BIT];
              r_btn_r  <= rx_data[BTN_R_BIT];
              r_x_sign <= rx_data[X_SIGN_BIT];
              r_y_sign <= rx_data[Y_SIGN_BIT];
              r_x_ovf  <= rx_data[X_OVF_BIT];
              r_y_ovf  <= rx_data[Y_OVF_BIT];
              r_state  <= BYTE1;
            end
          end
          BYTE1: begin
            r_byte1 <= rx_data;
            r_state <= BYTE2;
          end
`ifdef MOUSE_WHEEL_EN
          BYTE2: begin
            r_byte2 <= rx_data;
            r_state <= BYTE3;
          end
          BYTE3: begin
            xpos         <= w_x_next;
            ypos         <= w_y_next;
            left         <= r_btn_l;
            right        <= r_btn_r;
            wheel        <= signed'(rx_data[3:0]);
            packet_valid <= 1'b1;
            r_state      <= BYTE0;
          end
`else
          BYTE2: begin
            xpos         <= w_x_next;
            ypos         <= w_y_next;
            left         <= r_btn_l;
            right        <= r_btn_r;
            packet_valid <= 1'b1;
            r_state      <= BYTE0;
          end
`endif
          default: r_state <= BYTE0;
        endcase
      end
    end
  end

endmodule : mouse_position_tracker
`default_nettype wire

// File: tb/tb_mouse_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_position_tracker
// Description : Self-checking bench for mouse_position_tracker. Directed
//               PS/2 byte sequences; each expected packet result is queued
//               when stimulus is issued and a monitor pops and compares it
//               whenever packet_valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_position_tracker;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic        packet_valid;
  logic [3:0]  w_wheel_act;
`ifdef MOUSE_WHEEL_EN
  logic signed [3:0] wheel;
  assign w_wheel_act = wheel;
`else
  assign w_wheel_act = 4'h0;
`endif

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
    logic [3:0]  w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  mouse_position_tracker #(
    .MAX_X          (799),
    .MAX_Y          (599),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .xpos         (xpos),
    .ypos         (ypos),
    .left         (left),
    .right        (right),
    .packet_valid (packet_valid)
`ifdef MOUSE_WHEEL_EN
    ,
    .wheel        (wheel)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h", name, act, exp);
  endtask

  // Monitor: every packet_valid strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && packet_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_packet_valid", 64'(q.size()), 64'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("packet{x,y,l,r,wheel}",
            64'({xpos, ypos, left, right, w_wheel_act}), 64'(e));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // 3-byte movement packet; wheel builds append a zero Z byte
  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input int x, input int y, input logic l, input logic r);
    exp_t e;
    e = '{x: 12'(x), y: 12'(y), l: l, r: r, w: 4'h0};
    q.push_back(e);
    send(b0);
    send(b1);
    send(b2);
`ifdef MOUSE_WHEEL_EN
    send(8'h00);
`endif
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_xpos", 64'(xpos), 64'd0);
    chk("reset_ypos", 64'(ypos), 64'd0);
    chk("reset_buttons", 64'({left, right}), 64'd0);
    chk("reset_packet_valid", 64'(packet_valid), 64'd0);
    chk("reset_wheel", 64'(w_wheel_act), 64'd0);
    rst = 1'b0;

    // Basic move, Y clamped at the top row
    pkt(8'h08, 8'h05, 8'h03, 5, 0, 1'b0, 1'b0);
    // Negative dy moves down: y = 0 - (-10)
    pkt(8'h28, 8'h05, 8'hF6, 10, 10, 1'b0, 1'b0);
    // dx=-10 clamps at 0, dy=-5 -> y=15, left pressed
    pkt(8'h39, 8'hF6, 8'hFB, 0, 15, 1'b1, 1'b0);
    // Walk to x=795
    pkt(8'h08, 8'hFF, 8'h00, 255, 15, 1'b0, 1'b0);
    pkt(8'h08, 8'hFF, 8'h00, 510, 15, 1'b0, 1'b0);
    pkt(8'h08, 8'hFF, 8'h00, 765, 15, 1'b0, 1'b0);
    pkt(8'h08, 8'h1E, 8'h00, 795, 15, 1'b0, 1'b0);
    // Right-edge clamp
    pkt(8'h09, 8'h0A, 8'h00, 799, 15, 1'b1, 1'b0);
    pkt(8'h18, 8'hF6, 8'h00, 789, 15, 1'b0, 1'b0);
    // Byte without sync bit is dropped
    send(8'h00);
    pkt(8'h08, 8'h01, 8'h01, 790, 14, 1'b0, 1'b0);
    // Partial packet abandoned by timeout
    send(8'h08);
    send(8'h05);
    repeat (TO + 5) @(posedge clk);
    pkt(8'h08, 8'h02, 8'h00, 792, 14, 1'b0, 1'b0);
    // Right button
    pkt(8'h0A, 8'h00, 8'h00, 792, 14, 1'b0, 1'b1);
    // X overflow forces dx to 0; Y overflow forces dy to 0
    pkt(8'h48, 8'hFF, 8'h00, 792, 14, 1'b0, 1'b0);
    pkt(8'h88, 8'h00, 8'h7F, 792, 14, 1'b0, 1'b0);
    // dy=-255 steps toward the bottom edge, then clamp
    pkt(8'h28, 8'h00, 8'h01, 792, 269, 1'b0, 1'b0);
    pkt(8'h28, 8'h00, 8'h01, 792, 524, 1'b0, 1'b0);
    pkt(8'h28, 8'h00, 8'h01, 792, 599, 1'b0, 1'b0);
`ifdef MOUSE_WHEEL_EN
    begin
      exp_t e;
      e = '{x: 12'd792, y: 12'd599, l: 1'b0, r: 1'b0, w: 4'hF};
      q.push_back(e);
      send(8'h08);
      send(8'h00);
      send(8'h00);
      send(8'h0F);
    end
`endif
    drain();
    // Outputs hold between packets
    repeat (5) @(posedge clk);
    #1;
    chk("hold_xpos", 64'(xpos), 64'd792);
    chk("hold_ypos", 64'(ypos), 64'd599);

    // Reset mid-packet discards the partial packet and clears outputs
    send(8'h08);
    send(8'h05);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_xpos", 64'(xpos), 64'd0);
    chk("midrst_ypos", 64'(ypos), 64'd0);
    rst = 1'b0;
    pkt(8'h08, 8'h03, 8'h00, 3, 0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_mouse_position_tracker
`default_nettype wire
